// File: rtl/rau_bank_read_port.sv
// Single-ported register-file bank front end: arbitrates collector-unit operand reads
// against writeback, pairs same-row src1/src2 reads, and returns read data one cycle later.
module rau_bank_read_port #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          req_vld,
    input  logic [8*ADDR_W-1:0] req_addr,
    output logic [7:0]          req_ack,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [255:0]        wr_data,
    output logic                wr_ready,
    output logic                bank_rd_en,
    output logic [ADDR_W-1:0]   bank_rd_addr,
    output logic                bank_wr_en,
    output logic [ADDR_W-1:0]   bank_wr_addr,
    output logic [255:0]        bank_wr_data,
    input  logic [255:0]        bank_rdata,
    output logic [255:0]        bk_data,
    output logic [2:0]          bk_ocid,
    output logic                bk_vld,
    output logic                bk_bz,
    output logic                same_oc
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    // Round-robin pick: returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [3:0] rr_pick(input logic [7:0] vld, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (vld[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [2:0]        rr_ptr_r;
    logic [2:0]        starve_cnt_r;
    logic              bk_vld_r;
    logic              bk_bz_r;
    logic [2:0]        bk_ocid_r;
    logic              same_oc_r;

    logic              any_req_s;
    logic              starve_full_s;
    logic [3:0]        pick_s;
    logic [2:0]        grant_idx_s;
    logic [2:0]        partner_idx_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic [ADDR_W-1:0] partner_addr_s;
    logic              pair_s;
    logic              wr_acc_s;
    logic              rd_grant_s;
    logic [2:0]        rr_ptr_nxt_s;
    logic [2:0]        starve_cnt_nxt_s;

    // Candidate read selection and src1/src2 same-row pairing
    always_comb begin
        any_req_s      = |req_vld;
        starve_full_s  = (starve_cnt_r == STARVE_MAX);
        pick_s         = rr_pick(req_vld, rr_ptr_r);
        grant_idx_s    = pick_s[2:0];
        partner_idx_s  = grant_idx_s + 3'd1;
        grant_addr_s   = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
        partner_addr_s = req_addr[partner_idx_s*ADDR_W +: ADDR_W];
        // Only an operand-0 winner may drag its operand-1 sibling along
        if (!grant_idx_s[0] && req_vld[partner_idx_s] && (partner_addr_s == grant_addr_s)) begin
            pair_s = 1'b1;
        end else begin
            pair_s = 1'b0;
        end
    end

    // Write-versus-read decision for the single bank port; everything quiet in reset
    always_comb begin
        wr_ready   = 1'b1;
        wr_acc_s   = 1'b0;
        rd_grant_s = 1'b0;
        if (rst) begin
            wr_ready   = !(starve_full_s && any_req_s);
            wr_acc_s   = wr_req && wr_ready;
            rd_grant_s = pick_s[3] && !wr_acc_s;
        end else begin
            wr_ready   = 1'b1;
            wr_acc_s   = 1'b0;
            rd_grant_s = 1'b0;
        end
    end

    // SRAM port drive and requester acknowledges
    always_comb begin
        bank_wr_en   = wr_acc_s;
        bank_wr_addr = wr_addr;
        bank_wr_data = wr_data;
        bank_rd_en   = rd_grant_s;
        bank_rd_addr = grant_addr_s;
        req_ack      = 8'h00;
        if (rd_grant_s) begin
            req_ack[grant_idx_s] = 1'b1;
            if (pair_s) begin
                req_ack[partner_idx_s] = 1'b1;
            end else begin
                req_ack[partner_idx_s] = req_ack[partner_idx_s];
            end
        end else begin
            req_ack = 8'h00;
        end
    end

    // Next round-robin pointer and read-starvation count
    always_comb begin
        rr_ptr_nxt_s     = rr_ptr_r;
        starve_cnt_nxt_s = starve_cnt_r;
        if (rd_grant_s) begin
            rr_ptr_nxt_s = pair_s ? (grant_idx_s + 3'd2) : (grant_idx_s + 3'd1);
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
        if (!any_req_s || rd_grant_s) begin
            starve_cnt_nxt_s = 3'd0;
        end else if (!starve_full_s) begin
            starve_cnt_nxt_s = starve_cnt_r + 3'd1;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Arbitration state and the registered return-channel sideband
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r     <= 3'd0;
            starve_cnt_r <= 3'd0;
            bk_vld_r     <= 1'b0;
            bk_bz_r      <= 1'b0;
            bk_ocid_r    <= 3'd0;
            same_oc_r    <= 1'b0;
        end else begin
            rr_ptr_r     <= rr_ptr_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            bk_vld_r     <= rd_grant_s;
            bk_bz_r      <= wr_acc_s && any_req_s;
            same_oc_r    <= rd_grant_s && pair_s;
            if (rd_grant_s) begin
                bk_ocid_r <= grant_idx_s;
            end else begin
                bk_ocid_r <= bk_ocid_r;
            end
        end
    end

    // Read data arrives from the SRAM exactly when the sideband registers present it
    assign bk_data = bank_rdata;
    assign bk_vld  = bk_vld_r;
    assign bk_bz   = bk_bz_r;
    assign bk_ocid = bk_ocid_r;
    assign same_oc = same_oc_r;

endmodule

// File: tb/tb_rau_bank_read_port.sv
// Scoreboard bench for rau_bank_read_port: directed scenarios plus random traffic
// checked against a rule-level arbitration model and a bench-side write-first SRAM.
module tb_rau_bank_read_port;

    localparam int AW = 8;
    localparam int SL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      req_vld;
    logic [8*AW-1:0] req_addr;
    logic [7:0]      req_ack;
    logic            wr_req;
    logic [AW-1:0]   wr_addr;
    logic [255:0]    wr_data;
    logic            wr_ready;
    logic            bank_rd_en;
    logic [AW-1:0]   bank_rd_addr;
    logic            bank_wr_en;
    logic [AW-1:0]   bank_wr_addr;
    logic [255:0]    bank_wr_data;
    logic [255:0]    bank_rdata;
    logic [255:0]    bk_data;
    logic [2:0]      bk_ocid;
    logic            bk_vld;
    logic            bk_bz;
    logic            same_oc;

    always #5 clk = ~clk;

    rau_bank_read_port #(.ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_addr(req_addr), .req_ack(req_ack),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
        .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .bank_wr_data(bank_wr_data),
        .bank_rdata(bank_rdata),
        .bk_data(bk_data), .bk_ocid(bk_ocid), .bk_vld(bk_vld), .bk_bz(bk_bz), .same_oc(same_oc)
    );

    // Bench SRAM: write lands at the edge, read data one cycle after bank_rd_en
    logic [255:0] sram [256];
    logic         sram_clr;
    always @(posedge clk) begin
        if (sram_clr) begin
            for (int k = 0; k < 256; k++) sram[k] <= '0;
        end else if (bank_wr_en) begin
            sram[bank_wr_addr] <= bank_wr_data;
        end
        if (bank_rd_en) bank_rdata <= sram[bank_rd_addr];
    end

    typedef struct packed {
        logic [2:0]   ocid;
        logic         same;
        logic [255:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic         exp_bz;
    logic [7:0]   exp_ack;
    logic         exp_rdy, exp_wen, exp_ren;
    int           checks = 0;
    int           failures = 0;

    // Reference model state
    logic [255:0] gold [256];
    int           m_rr, m_starve;
    logic [7:0]   pend;
    logic [AW-1:0] paddr [8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: combinational outputs mid-low-phase, return channel after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            chk("req_ack", 256'(req_ack), 256'(exp_ack));
            chk("wr_ready", 256'(wr_ready), 256'(exp_rdy));
            chk("bank_wr_en", 256'(bank_wr_en), 256'(exp_wen));
            chk("bank_rd_en", 256'(bank_rd_en), 256'(exp_ren));
            #2;
            if (rst === 1'b0) begin
                chk("rst_req_ack", 256'(req_ack), 256'(8'h00));
                chk("rst_wr_ready", 256'(wr_ready), 256'(1'b1));
                chk("rst_bank_rd_en", 256'(bank_rd_en), 256'(1'b0));
                chk("rst_bank_wr_en", 256'(bank_wr_en), 256'(1'b0));
            end
            @(posedge clk); #2;
            chk("bk_bz", 256'(bk_bz), 256'(exp_bz));
            if (bk_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bk_vld_unexpected actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("bk_ocid", 256'(bk_ocid), 256'(e.ocid));
                    chk("same_oc", 256'(same_oc), 256'(e.same));
                    chk("bk_data", bk_data, e.data);
                end
            end else begin
                if (exp_q.size() != 0) begin
                    checks++; failures++;
                    $display("FAIL bk_vld_missing actual=%0b expected=1", bk_vld);
                    exp_q.delete();
                end
                chk("same_oc_idle", 256'(same_oc), 256'(1'b0));
            end
            if (rst === 1'b0) chk("rst_bk_ocid", 256'(bk_ocid), 256'(3'd0));
        end
    end

    // One bus cycle: drive, predict from the arbitration rules, advance the model
    task automatic step(input logic do_wr, input logic [AW-1:0] wa, input logic [255:0] wd,
                        input logic rst_mid);
        logic any, rdy, acc, grant, pair;
        int gi;
        logic [7:0] ack;
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        sram_clr = 1'b0;
        req_vld = pend;
        for (int k = 0; k < 8; k++) req_addr[k*AW +: AW] = paddr[k];
        wr_req = do_wr; wr_addr = wa; wr_data = wd;
        any   = |pend;
        rdy   = !(m_starve == SL && any);
        acc   = do_wr && rdy;
        grant = any && !acc;
        ack = 8'h00; gi = 0; pair = 1'b0;
        if (grant) begin
            for (int k = 7; k >= 0; k--) if (pend[(m_rr + k) % 8]) gi = (m_rr + k) % 8;
            ack[gi] = 1'b1;
            if (gi % 2 == 0 && pend[gi+1] && paddr[gi+1] == paddr[gi]) begin
                pair = 1'b1;
                ack[gi+1] = 1'b1;
            end
        end
        #1;
        exp_ack = ack; exp_rdy = rdy; exp_wen = acc; exp_ren = grant;
        if (rst_mid) begin
            #2;
            rst = 1'b0;
            m_rr = 0; m_starve = 0; exp_bz = 1'b0;
        end else begin
            if (acc) gold[wa] = wd;
            if (grant) begin
                e.ocid = 3'(gi); e.same = pair; e.data = gold[paddr[gi]];
                exp_q.push_back(e);
                m_rr = (gi + (pair ? 2 : 1)) % 8;
                m_starve = 0;
            end else if (!any) begin
                m_starve = 0;
            end else if (m_starve < SL) begin
                m_starve++;
            end
            exp_bz = acc && any;
            pend = pend & ~ack;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 256'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; sram_clr = 1'b1;
        req_vld = 8'hFF; req_addr = '0; wr_req = 1'b1; wr_addr = 8'h00; wr_data = 256'h0;
        exp_ack = 8'h00; exp_rdy = 1'b1; exp_wen = 1'b0; exp_ren = 1'b0; exp_bz = 1'b0;
        m_rr = 0; m_starve = 0; pend = 8'h00;
        for (int k = 0; k < 256; k++) gold[k] = '0;
        for (int k = 0; k < 8; k++) paddr[k] = 8'(k);
        repeat (3) @(posedge clk);

        // Requesters 0 and 7: 0 first from pointer 0, then 7
        pend = 8'b1000_0001;
        idle(3);
        // Same-row src1/src2 of collector 1 served in one read
        paddr[2] = 8'h15; paddr[3] = 8'h15; pend = 8'b0000_1100;
        idle(2);
        // Writeback held against a waiting reader: four writes, then the read forces through
        pend = 8'b0010_0000; paddr[5] = 8'h09;
        for (int k = 0; k < 6; k++) step(1'b1, 8'h09, {8{32'h1234_0000 + 32'(k)}}, 1'b0);
        idle(2);
        // Read the row written in the previous cycle
        step(1'b1, 8'h03, {32{8'hAA}}, 1'b0);
        pend = 8'b0100_0000; paddr[6] = 8'h03;
        idle(2);
        // Reset landing on a grant cycle, then a lone requester 4
        pend = 8'b0010_0000; paddr[5] = 8'h20;
        idle(1);
        pend = 8'b0001_0000; paddr[4] = 8'h03;
        step(1'b0, 8'h00, 256'h0, 1'b1);
        idle(2);
        // All requesters continuously pending on distinct rows
        for (int k = 0; k < 8; k++) paddr[k] = 8'(16 + k);
        for (int k = 0; k < 10; k++) begin
            pend = 8'hFF;
            step(1'b0, 8'h00, 256'h0, 1'b0);
        end
        pend = 8'h00;
        idle(2);

        // Random traffic with occasional pairs, writebacks and resets
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 3) begin
                    pend[i] = 1'b1;
                    if (i % 2 == 1 && $urandom_range(0, 1) == 1) paddr[i] = paddr[i-1];
                    else paddr[i] = 8'($urandom_range(0, 15));
                end
            end
            step($urandom_range(0, 9) < 3, 8'($urandom_range(0, 15)),
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 199) == 0);
        end
        pend = 8'h00;
        idle(4);
        @(posedge clk); #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rau_bank_read_port.md
RAU_BANK_READ_PORT -- requirements
Module: rau_bank_read_port

Interface
REQ-001 Parameter ADDR_W, default 8: bank row address width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive read-stall cycles tolerated before reads take priority over writes.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req_vld  in  8  read request per requester i; i = {oc[1:0], operand}, operand 0 = src1, 1 = src2.
REQ-006 req_addr  in  8*ADDR_W  row address of requester i at bits [i*ADDR_W +: ADDR_W].
REQ-007 req_ack  out  8  combinational; bit i high = request i accepted this cycle.
REQ-008 wr_req  in  1  writeback request; wr_addr in ADDR_W, wr_data in 256.
REQ-009 wr_ready  out  1  combinational; write accepted when wr_req && wr_ready.
REQ-010 bank_rd_en, bank_rd_addr[ADDR_W], bank_wr_en, bank_wr_addr[ADDR_W], bank_wr_data[256]  out  SRAM port.
REQ-011 bank_rdata  in  256  SRAM read data, valid one cycle after bank_rd_en.
REQ-012 bk_data out 256, bk_ocid out 3, bk_vld out 1, bk_bz out 1, same_oc out 1  return channel to collector units.

Function
REQ-013 Bank single-ported; per cycle exactly one of: one write, one read grant, idle.
REQ-014 Write wins when wr_req=1 and starve_cnt < STARVE_LIMIT; then bank_wr_en=1, bank_wr_addr=wr_addr, bank_wr_data=wr_data, req_ack=0.
REQ-015 wr_ready = !(starve_cnt == STARVE_LIMIT && |req_vld).
REQ-016 starve_cnt (3 bits): +1 in each cycle with |req_vld and no read grant, saturating at STARVE_LIMIT; cleared on any read grant or when req_vld=0.
REQ-017 Read grant: when |req_vld and no write accepted, grant lowest index i >= rr_ptr with req_vld[i], wrapping 7->0; rr_ptr updates to (i+1) mod 8.
REQ-018 Grant cycle T: req_ack[i]=1, bank_rd_en=1, bank_rd_addr=req_addr[i].
REQ-019 Pairing: if granted i has operand 0, req_vld[i+1]=1 and req_addr[i+1]==req_addr[i], req_ack[i+1] also asserts, rr_ptr=(i+2) mod 8, same_oc registered 1; operand-1 grants never pair.
REQ-020 Cycle T+1: bk_vld=1, bk_ocid=i (registered), bk_data=bank_rdata (pass-through), same_oc per REQ-019; otherwise bk_vld=0, same_oc=0.
REQ-021 bk_bz registered: 1 in T+1 iff at T a write was accepted while |req_vld; never high with bk_vld.
REQ-022 Read-after-write same address in consecutive cycles returns the newly written data (SRAM write-first; block adds no forwarding).
REQ-023 Requesters hold req_vld/req_addr until acked; a requester deasserting unacked is simply not granted; req_ack never asserts without req_vld.
REQ-024 Back-to-back grants each cycle permitted; throughput 1 read/cycle.

Reset
REQ-025 On rst=0 asynchronously: bk_vld=0, bk_bz=0, bk_ocid=0, same_oc=0, rr_ptr=0, starve_cnt=0; in-flight read discarded (no bk_vld after release).
REQ-026 During reset combinational outputs req_ack=0, bank_rd_en=0, bank_wr_en=0, wr_ready=1.
REQ-027 First grant after reset release follows rr_ptr=0.

Verification
REQ-028 req_vld=8'b1000_0001, no writes -> grants i=0 at T, i=7 at T+1; bk_ocid 0 then 7, bk_vld high T+1, T+2.
REQ-029 req_vld[2],[3] high, both addr 0x15 -> req_ack=8'b0000_1100 same cycle, next cycle bk_ocid=2, same_oc=1, single bank_rd_en.
REQ-030 wr_req held high, req_vld[5] high -> writes accepted 4 cycles (bk_bz=1 each following cycle), 5th cycle wr_ready=0, req_ack[5]=1, starve_cnt 0.
REQ-031 Write 0xAA.. to addr 3 at T, request addr 3 granted T+1 -> bk_data=0xAA.. at T+2.
REQ-032 rst asserted in grant cycle T -> bk_vld=0 at T+1; after release, requester 4 alone pending -> granted with rr_ptr starting at 0.
REQ-033 All 8 requesters held high -> acks rotate 0..7 one per cycle, no requester granted twice within 8 cycles (pairing disabled via distinct addresses).
